bsg_dmc_ui_arbiter: RTL

Round-robin arbiter sharing one bsg_dmc user-interface (app_*) port among `num_req_p` requesters. Grants one command at a time, streams the owner's write burst into the write-data FIFO, and records the requester id of every read in an in-order tag FIFO so returning read bursts are steered to the correct requester. Sits between client engines (trace replay, DMA, cores) and the controller's app_* port, in the `ui_clk` domain.

---
 rtl/bsg_dmc_ui_arbiter.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_dmc_ui_arbiter.sv
// Round-robin arbiter that shares one bsg_dmc app_* port among several
// requesters. It grants one command at a time, streams the owner's write
// burst into the write-data FIFO, and remembers the owner of each read in
// an in-order tag FIFO so that returning read beats reach the right requester.
module bsg_dmc_ui_arbiter #(
  parameter int num_req_p       = 2,
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 32,
  parameter int ui_burst_len_p  = 4,
  parameter int rd_tag_els_p    = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,

  input  logic [num_req_p-1:0]                     req_v_i,
  input  logic [3*num_req_p-1:0]                   req_cmd_i,
  input  logic [ui_addr_width_p*num_req_p-1:0]     req_addr_i,
  output logic [num_req_p-1:0]                     req_yumi_o,

  input  logic [num_req_p-1:0]                     req_wdata_v_i,
  input  logic [ui_data_width_p*num_req_p-1:0]     req_wdata_i,
  input  logic [(ui_data_width_p/8)*num_req_p-1:0] req_wmask_i,
  output logic [num_req_p-1:0]                     req_wdata_ready_o,

  output logic [num_req_p-1:0]                     rd_v_o,
  output logic [ui_data_width_p-1:0]               rd_data_o,
  output logic                                     rd_end_o,

  output logic [ui_addr_width_p-1:0]               app_addr_o,
  output logic [2:0]                               app_cmd_o,
  output logic                                     app_en_o,
  input  logic                                     app_rdy_i,

  output logic                                     app_wdf_wren_o,
  output logic [ui_data_width_p-1:0]               app_wdf_data_o,
  output logic [(ui_data_width_p/8)-1:0]           app_wdf_mask_o,
  output logic                                     app_wdf_end_o,
  input  logic                                     app_wdf_rdy_i,

  input  logic                                     app_rd_data_valid_i,
  input  logic [ui_data_width_p-1:0]               app_rd_data_i,
  input  logic                                     app_rd_data_end_i,

  output logic                                     error_o
);

  localparam int mask_w    = ui_data_width_p / 8;
  localparam int id_w      = $clog2(num_req_p);
  localparam int tag_ptr_w = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1;
  localparam int tag_cnt_w = $clog2(rd_tag_els_p + 1);
  localparam int beat_w    = (ui_burst_len_p > 1) ? $clog2(ui_burst_len_p) : 1;

  localparam logic [2:0] cmd_write = 3'b000;
  localparam logic [2:0] cmd_read  = 3'b001;

  typedef enum logic [1:0] {
    e_idle,
    e_cmd,
    e_wdata
  } state_e;

  state_e                     state_q, state_d;
  logic [id_w-1:0]            rr_ptr_q, rr_ptr_d;
  logic [id_w-1:0]            owner_q, owner_d;
  logic [2:0]                 cmd_q, cmd_d;
  logic [ui_addr_width_p-1:0] addr_q, addr_d;
  logic [beat_w-1:0]          beat_cnt_q, beat_cnt_d;
  logic                       error_q, error_d;

  logic [id_w-1:0]            tag_mem_q [rd_tag_els_p];
  logic [id_w-1:0]            tag_mem_d [rd_tag_els_p];
  logic [tag_ptr_w-1:0]       tag_wr_ptr_q, tag_wr_ptr_d;
  logic [tag_ptr_w-1:0]       tag_rd_ptr_q, tag_rd_ptr_d;
  logic [tag_cnt_w-1:0]       tag_cnt_q, tag_cnt_d;

  logic [2:0]                 cmd_a   [num_req_p];
  logic [ui_addr_width_p-1:0] addr_a  [num_req_p];
  logic [ui_data_width_p-1:0] wdata_a [num_req_p];
  logic [mask_w-1:0]          wmask_a [num_req_p];

  logic [num_req_p-1:0]       eligible;
  logic                       illegal_seen;
  logic                       grant_v;
  logic [id_w-1:0]            grant_id;
  logic [num_req_p-1:0]       grant_oh;

  logic                       tag_full;
  logic                       tag_empty;
  logic                       tag_push;
  logic                       tag_pop;
  logic                       in_wdata;
  logic                       beat_last;
  logic                       beat_accept;

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign cmd_a[g]   = req_cmd_i[3*g +: 3];
    assign addr_a[g]  = req_addr_i[ui_addr_width_p*g +: ui_addr_width_p];
    assign wdata_a[g] = req_wdata_i[ui_data_width_p*g +: ui_data_width_p];
    assign wmask_a[g] = req_wmask_i[mask_w*g +: mask_w];
  end

  function automatic logic [tag_ptr_w-1:0] tag_inc(input logic [tag_ptr_w-1:0] p);
    return (p == tag_ptr_w'(rd_tag_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tag_full    = (tag_cnt_q == tag_cnt_w'(rd_tag_els_p));
  assign tag_empty   = (tag_cnt_q == '0);
  assign in_wdata    = (state_q == e_wdata);
  assign beat_last   = (beat_cnt_q == beat_w'(ui_burst_len_p - 1));
  assign beat_accept = app_wdf_wren_o & app_wdf_rdy_i;

  // Eligibility and round-robin winner search starting at rr_ptr.
  always_comb begin
    int idx;
    eligible     = '0;
    illegal_seen = 1'b0;
    grant_v      = 1'b0;
    grant_id     = '0;
    grant_oh     = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (req_v_i[i] && (cmd_a[i] != cmd_write) && (cmd_a[i] != cmd_read)) begin
        illegal_seen = 1'b1;
      end
      eligible[i] = req_v_i[i] & ((cmd_a[i] == cmd_write) |
                                  ((cmd_a[i] == cmd_read) & ~tag_full));
    end
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_v && eligible[idx]) begin
        grant_v  = 1'b1;
        grant_id = id_w'(idx);
      end
    end
    if (grant_v) grant_oh[grant_id] = 1'b1;
  end

  // Next-state logic for the command FSM, owner registers and beat counter.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      e_idle: begin
        if (grant_v) begin
          owner_d = grant_id;
          cmd_d   = cmd_a[grant_id];
          addr_d  = addr_a[grant_id];
          state_d = e_cmd;
        end
      end
      e_cmd: begin
        if (app_rdy_i) begin
          rr_ptr_d = (owner_q == id_w'(num_req_p - 1)) ? '0 : owner_q + 1'b1;
          state_d  = (cmd_q == cmd_read) ? e_idle : e_wdata;
        end
      end
      e_wdata: begin
        if (beat_accept) begin
          if (beat_last) begin
            beat_cnt_d = '0;
            state_d    = e_idle;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // Tag FIFO bookkeeping and sticky error accumulation.
  always_comb begin
    tag_push     = (state_q == e_cmd) & app_rdy_i & (cmd_q == cmd_read);
    tag_pop      = app_rd_data_valid_i & app_rd_data_end_i & ~tag_empty;
    tag_mem_d    = tag_mem_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    tag_cnt_d    = tag_cnt_q;
    if (tag_push) begin
      tag_mem_d[tag_wr_ptr_q] = owner_q;
      tag_wr_ptr_d            = tag_inc(tag_wr_ptr_q);
    end
    if (tag_pop) begin
      tag_rd_ptr_d = tag_inc(tag_rd_ptr_q);
    end
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    error_d = error_q | illegal_seen | (app_rd_data_valid_i & tag_empty);
  end

  // All state registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_idle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      error_q      <= 1'b0;
      tag_mem_q    <= '{default: '0};
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      tag_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      error_q      <= error_d;
      tag_mem_q    <= tag_mem_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
    end
  end

  // Read return steering; reset gating keeps pass-through strobes quiet.
  always_comb begin
    rd_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      rd_v_o[i] = reset_n_i & app_rd_data_valid_i & ~tag_empty &
                  (tag_mem_q[tag_rd_ptr_q] == id_w'(i));
    end
    rd_end_o  = reset_n_i & app_rd_data_valid_i & app_rd_data_end_i & ~tag_empty;
    rd_data_o = app_rd_data_i;
  end

  // Write data path muxed from the current owner while streaming a burst.
  always_comb begin
    req_wdata_ready_o = '0;
    app_wdf_wren_o    = in_wdata & req_wdata_v_i[owner_q];
    app_wdf_data_o    = in_wdata ? wdata_a[owner_q] : '0;
    app_wdf_mask_o    = in_wdata ? wmask_a[owner_q] : '0;
    app_wdf_end_o     = app_wdf_wren_o & beat_last;
    if (in_wdata) req_wdata_ready_o[owner_q] = app_wdf_rdy_i;
  end

  assign req_yumi_o = (reset_n_i && state_q == e_idle) ? grant_oh : '0;
  assign app_en_o   = (state_q == e_cmd);
  assign app_addr_o = addr_q;
  assign app_cmd_o  = cmd_q;
  assign error_o    = error_q;

endmodule
